// File: rtl/f16_pkg.sv
// rtl/f16_pkg.sv - FP16 field layout, saturation pattern and sequencer state encoding
package f16_pkg;

  localparam int F16_W        = 16;
  localparam int F16_FRAC_W   = 10;
  localparam int F16_EXP_W    = 5;
  localparam int F16_EXP_LSB  = F16_FRAC_W;
  localparam int F16_EXP_MSB  = F16_FRAC_W + F16_EXP_W - 1;
  localparam int F16_SIGN_BIT = F16_W - 1;

  localparam logic [F16_EXP_W-1:0] F16_EXP_SAT = 5'h1F;
  localparam logic [F16_W-1:0]     F16_ONE     = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // All-ones exponent is what the core produces on overflow (inf/NaN).
  function automatic logic f16_is_sat(input logic [F16_W-1:0] h);
    return h[F16_EXP_MSB:F16_EXP_LSB] == F16_EXP_SAT;
  endfunction

endpackage

// File: rtl/f16_dot_seq.sv
// rtl/f16_dot_seq.sv - sequential FP16 dot-product initiator driving an external x*y+z core
// Optional sticky saturation flag enabled by defining F16_DOT_OVF_FLAG_EN.
module f16_dot_seq
  import f16_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      init_acc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [15:0]      in_y,
  output logic [15:0]      fmac_x,
  output logic [15:0]      fmac_y,
  output logic [15:0]      fmac_z,
  input  logic [15:0]      fmac_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic             busy,
  output logic             ovf
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [F16_W-1:0] acc;

  assign cnt_nxt = cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      fmac_x     <= '0;
      fmac_y     <= '0;
      fmac_z     <= '0;
      out_result <= '0;
      acc        <= '0;
      cnt        <= '0;
      len_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            acc   <= init_acc;
            busy  <= 1'b1;
            if (len == '0) begin
              out_result <= init_acc;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (in_valid && in_ready) begin
            fmac_x   <= in_x;
            fmac_y   <= in_y;
            fmac_z   <= acc;
            in_ready <= 1'b0;
            state    <= CAPT;
          end
        end
        CAPT: begin
          // Core is combinational, so fmac_r already reflects the operands issued last edge.
          acc <= fmac_r;
          cnt <= cnt_nxt;
          if (cnt_nxt == len_q) begin
            out_result <= fmac_r;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ISSUE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef F16_DOT_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (state == CAPT && f16_is_sat(fmac_r)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_f16_dot_seq.sv
// tb/tb_f16_dot_seq.sv - scoreboard bench for f16_dot_seq with a behavioural FP16 x*y+z core
module tb_f16_dot_seq;
  import f16_pkg::*;

`ifdef F16_DOT_OVF_FLAG_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] init_acc;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x, in_y;
  logic [15:0] fmac_x, fmac_y, fmac_z, fmac_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        busy;
  logic        ovf;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   results_seen = 0;
  int   ready_block = 0;

  always #5 clk = ~clk;

  f16_dot_seq #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .init_acc(init_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .fmac_x(fmac_x), .fmac_y(fmac_y), .fmac_z(fmac_z), .fmac_r(fmac_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy), .ovf(ovf)
  );

  function automatic real f16_to_real(input logic [15:0] h);
    int  e;
    int  f;
    real v;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0)       v = real'(f) * (2.0 ** -24);
    else if (e == 31) v = 1.0e10;
    else              v = real'(1024 + f) * (2.0 ** real'(e - 25));
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] real_to_f16(input real r);
    logic s;
    real  a, m;
    int   ex, f;
    logic [15:0] h;
    s = (r < 0.0);
    a = s ? -r : r;
    if (a == 0.0) return {s, 15'd0};
    if (a >= 65520.0) return {s, 5'h1F, 10'd0};
    m = a;
    ex = 0;
    for (int i = 0; i < 64; i++) if (m >= 2.0) begin m = m / 2.0; ex++; end
    for (int i = 0; i < 64; i++) if (m < 1.0) begin m = m * 2.0; ex--; end
    if (ex < -14) begin
      f = $rtoi(a * (2.0 ** 24) + 0.5);
      if (f >= 1024) return {s, 5'd1, 10'd0};
      h = 16'(f);
      return {s, 5'd0, h[9:0]};
    end
    f = $rtoi((m - 1.0) * 1024.0 + 0.5);
    if (f == 1024) begin f = 0; ex++; end
    if (ex > 15) return {s, 5'h1F, 10'd0};
    h = 16'(f);
    return {s, 5'(ex + 15), h[9:0]};
  endfunction

  function automatic logic [15:0] fma16(input logic [15:0] x, y, z);
    return real_to_f16(f16_to_real(x) * f16_to_real(y) + f16_to_real(z));
  endfunction

  // Stand-in for the external combinational FMAC core.
  always_comb fmac_r = fma16(fmac_x, fmac_y, fmac_z);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    return {r[15], 5'($urandom_range(12, 17)), r[9:0]};
  endfunction

  // Downstream ready: random unless a hold window is requested.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_block > 0) begin
        out_ready = 1'b0;
        ready_block--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold stability.
  logic        prev_hold = 1'b0;
  logic [15:0] held_val = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", 32'(out_result), 32'(held_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", 32'(out_result), 32'(e.res));
          chk("result_ovf", 32'(ovf), 32'(e.ovf));
        end
        results_seen++;
      end
      prev_hold = out_valid && !out_ready;
      held_val  = out_result;
    end
  end

  task automatic start_job(input int n, input logic [15:0] init);
    start    = 1'b1;
    len      = 8'(n);
    init_acc = init;
    @(posedge clk);
    #1;
    start    = 1'b0;
    len      = 8'($urandom);
    init_acc = 16'($urandom);
  endtask

  task automatic send_pair(input logic [15:0] x, input logic [15:0] y, input int gap, input bit lat_chk);
    int budget;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    budget = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x = 16'($urandom);
    in_y = 16'($urandom);
    if (lat_chk) begin
      @(negedge clk);
      chk("lat_capt_no_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid_2clk", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_results(input int n);
    int budget;
    budget = 0;
    while (results_seen < n && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("result_count", 32'(results_seen), 32'(n));
  endtask

  task automatic push_exp(input logic [15:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [15:0] xs[$];
    logic [15:0] ys[$];
    logic [15:0] acc_m, init_v;
    logic        ovf_m;
    int          n, nres, len0_ir;

    rst_n = 1'b0; start = 1'b0; len = '0; init_acc = '0;
    in_valid = 1'b0; in_x = '0; in_y = '0;
    nres = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_fmac", 32'({fmac_x, fmac_y} | 32'(fmac_z)), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed: 1*2 + 2*3 = 8.0
    push_exp(16'h4800, 1'b0);
    start_job(2, 16'h0000);
    chk("busy_after_start", 32'(busy), 32'd1);
    send_pair(16'h3C00, 16'h4000, 0, 1'b0);
    send_pair(16'h4000, 16'h4200, 0, 1'b1);
    nres++;
    wait_results(nres);
    chk("idle_after_job1", 32'(busy), 32'd0);

    // Zero-length job returns init immediately without requesting operands.
    push_exp(F16_ONE, 1'b0);
    start_job(0, F16_ONE);
    chk("len0_valid_next_clk", 32'(out_valid), 32'd1);
    chk("len0_in_ready", 32'(in_ready), 32'd0);
    nres++;
    len0_ir = 0;
    for (int i = 0; i < 50 && results_seen < nres; i++) begin
      @(negedge clk);
      if (in_ready) len0_ir++;
    end
    wait_results(nres);
    chk("len0_no_in_ready", 32'(len0_ir), 32'd0);

    // len=3 with input gaps, start pulses while busy, output held low.
    xs = '{rand_op(), rand_op(), rand_op()};
    ys = '{rand_op(), rand_op(), rand_op()};
    init_v = rand_op();
    acc_m = init_v;
    for (int i = 0; i < 3; i++) acc_m = fma16(xs[i], ys[i], acc_m);
    push_exp(acc_m, 1'b0);
    start_job(3, init_v);
    send_pair(xs[0], ys[0], 2, 1'b0);
    start_job(1, 16'h7BFF);
    send_pair(xs[1], ys[1], 3, 1'b0);
    ready_block = 10;
    send_pair(xs[2], ys[2], 1, 1'b1);
    start = 1'b1;
    len = 8'd1;
    init_acc = 16'h5555;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    nres++;
    wait_results(nres);
    chk("idle_after_hold", 32'(busy), 32'd0);

    // Saturating product.
    push_exp(16'h7C00, OVF_ON);
    start_job(1, 16'h0000);
    send_pair(16'h7800, 16'h7800, 0, 1'b0);
    nres++;
    wait_results(nres);
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_held_idle", 32'(ovf), 32'(OVF_ON));

    // Randomized jobs against the arithmetic model.
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 6);
      init_v = rand_op();
      acc_m = init_v;
      ovf_m = 1'b0;
      xs.delete();
      ys.delete();
      for (int i = 0; i < n; i++) begin
        xs.push_back(rand_op());
        ys.push_back(rand_op());
        acc_m = fma16(xs[i], ys[i], acc_m);
        if (acc_m[14:10] == 5'h1F) ovf_m = OVF_ON;
      end
      push_exp(acc_m, ovf_m);
      start_job(n, init_v);
      chk("ovf_cleared_at_start", 32'(ovf), 32'd0);
      for (int i = 0; i < n; i++) send_pair(xs[i], ys[i], $urandom_range(0, 2), 1'b0);
      nres++;
      wait_results(nres);
    end

    // Abort during CAPT of a len=4 job.
    push_exp(16'h0000, 1'b0);
    start_job(4, rand_op());
    send_pair(rand_op(), rand_op(), 0, 1'b0);
    send_pair(rand_op(), rand_op(), 0, 1'b0);
    send_pair(rand_op(), rand_op(), 0, 1'b0);
    rst_n = 1'b0;
    #2;
    void'(exp_q.pop_back());
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_fmac", 32'({fmac_x, fmac_y} | 32'(fmac_z)), 32'd0);
    chk("abort_out_result", 32'(out_result), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_output", 32'(results_seen), 32'(nres));
    push_exp(16'h3C00, 1'b0);
    start_job(1, 16'h0000);
    send_pair(16'h3800, 16'h4000, 0, 1'b0);
    nres++;
    wait_results(nres);

    repeat (10) begin @(posedge clk); #1; end
    chk("no_extra_results", 32'(results_seen), 32'(nres));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
